// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants for the FIR tap-chain controller: sample
//               width, controller state encodings and the flat-bus slice
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Samples, weights and sums are Q1.(FIR_DATA_WIDTH-1) two's complement.
  localparam int FIR_DATA_WIDTH = 24;

  // Controller states. The encoding is fixed because the legacy debug
  // register map exposes it.
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // LSB position of element idx in a flat bus of width-bit elements.
  function automatic int unsigned slice_lsb(input int unsigned idx,
                                            input int unsigned width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_out_fifo
// Description : Synchronous FIFO for captured chain results. The head is
//               visible combinationally; a pop on an empty FIFO is ignored,
//               and a push while full is accepted when a pop happens in the
//               same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] iv_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] ov_head,
  output logic             o_empty,
  output logic [AW:0]      ov_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full   = (count_q == FULL_CNT);
  assign o_empty  = (count_q == '0);
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!w_full || w_pop);
  // Report zero when empty so the output never shows stale storage.
  assign ov_head  = o_empty ? '0 : mem_q[rd_ptr_q];
  assign ov_count = count_q;

  // Storage array; no reset needed because the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= iv_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap on the power-of-two depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap_ctrl
// Description : Sequencer for a transposed-form FIR tap chain. Accepts samples
//               on valid/ready, pulses the chain enable, captures the chain
//               output two cycles after acceptance into an output FIFO, holds
//               double-buffered coefficients and can zero-flush the chain.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_ctrl
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int NUM_TAPS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [DATA_WIDTH-1:0]          iv_din,
  input  logic                           i_din_valid,
  output logic                           o_din_ready,
  output logic                           o_tap_en,
  output logic [DATA_WIDTH-1:0]          ov_tap_din,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  input  logic [DATA_WIDTH-1:0]          iv_chain_sum,
  output logic [DATA_WIDTH-1:0]          ov_dout,
  output logic                           o_dout_valid,
  input  logic                           i_dout_ready,
  input  logic                           i_cfg_we,
  input  logic [ADDR_WIDTH-1:0]          iv_cfg_addr,
  input  logic [DATA_WIDTH-1:0]          iv_cfg_data,
  input  logic                           i_cfg_commit,
  input  logic                           i_flush,
  output logic                           o_busy
);

  localparam int CNT_W = $clog2(OUT_DEPTH);
  // Flush counter runs 0..NUM_TAPS+1: NUM_TAPS issue cycles, one cycle where
  // the last enable is visible, one cycle for that step's capture slot.
  localparam int FC_W = $clog2(NUM_TAPS + 2);
  localparam logic [FC_W-1:0]    FC_STEPS  = FC_W'(NUM_TAPS);
  localparam logic [FC_W-1:0]    FC_DONE   = FC_W'(NUM_TAPS + 1);
  localparam logic [CNT_W+1:0]   OCC_LIMIT = (CNT_W+2)'(OUT_DEPTH);

  logic [1:0]                     state_q, state_d;
  logic                           commit_pend_q, commit_pend_d;
  logic                           flush_pend_q, flush_pend_d;
  logic                           commit_clr, flush_clr;
  logic [FC_W-1:0]                flush_cnt_q, flush_cnt_d;
  logic                           tap_en_q, tap_en_d;
  logic [DATA_WIDTH-1:0]          tap_din_q, tap_din_d;
  logic                           s1_q;       // sample in the tap-update stage
  logic                           s2_q;       // sample in the capture stage
  logic                           ready_q, ready_d;
  logic [NUM_TAPS*DATA_WIDTH-1:0] shadow_q, active_q;

  logic                           w_accept;
  logic                           w_pop;
  logic                           w_flush_step;
  logic                           w_addr_ok;
  logic                           w_fifo_empty;
  logic [CNT_W:0]                 w_fifo_count;
  logic [CNT_W:0]                 w_count_next;
  logic [CNT_W+1:0]               w_occ_next;

  assign w_accept     = i_din_valid && ready_q;
  assign w_pop        = i_dout_ready && !w_fifo_empty;
  assign w_flush_step = (state_q == ST_FLUSH) && (flush_cnt_q < FC_STEPS);
  assign w_addr_ok    = (32'(iv_cfg_addr) < 32'(NUM_TAPS));

  assign o_din_ready  = ready_q;
  assign o_tap_en     = tap_en_q;
  assign ov_tap_din   = tap_din_q;
  assign ov_weights   = active_q;
  assign o_dout_valid = !w_fifo_empty;
  assign o_busy       = (state_q != ST_RUN) || commit_pend_q || flush_pend_q;

  // Sequencing FSM: drain in-flight samples, then swap and/or flush.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    commit_clr  = 1'b0;
    flush_clr   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (commit_pend_q || flush_pend_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_q && !s2_q) begin
          if (commit_pend_q) begin
            state_d = ST_SWAP;
          end else begin
            state_d     = ST_FLUSH;
            flush_clr   = 1'b1;
            flush_cnt_d = '0;
          end
        end
      end
      ST_SWAP: begin
        commit_clr = 1'b1;
        if (flush_pend_q) begin
          state_d     = ST_FLUSH;
          flush_clr   = 1'b1;
          flush_cnt_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FC_DONE) state_d = ST_RUN;
        else                        flush_cnt_d = flush_cnt_q + FC_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Next-cycle request flags, chain drive and registered input-ready credit.
  always_comb begin
    // Flags clear on service; a new request in the same cycle wins so it is
    // not lost.
    commit_pend_d = (commit_pend_q && !commit_clr) || i_cfg_commit;
    flush_pend_d  = (flush_pend_q && !flush_clr) || i_flush;
    tap_en_d      = w_accept || w_flush_step;
    tap_din_d     = tap_din_q;
    if (w_accept)          tap_din_d = iv_din;
    else if (w_flush_step) tap_din_d = '0;
    // Occupancy after this edge: FIFO entries plus samples still in flight.
    w_count_next = w_fifo_count + {{CNT_W{1'b0}}, s2_q} - {{CNT_W{1'b0}}, w_pop};
    w_occ_next   = {1'b0, w_count_next} + {{(CNT_W+1){1'b0}}, w_accept}
                 + {{(CNT_W+1){1'b0}}, s1_q};
    ready_d      = (state_d == ST_RUN) && !commit_pend_d && !flush_pend_d
                 && (w_occ_next < OCC_LIMIT);
  end

  // Control and pipeline registers; reset aborts any swap or flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_RUN;
      commit_pend_q <= 1'b0;
      flush_pend_q  <= 1'b0;
      flush_cnt_q   <= '0;
      tap_en_q      <= 1'b0;
      tap_din_q     <= '0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_pend_q <= commit_pend_d;
      flush_pend_q  <= flush_pend_d;
      flush_cnt_q   <= flush_cnt_d;
      tap_en_q      <= tap_en_d;
      tap_din_q     <= tap_din_d;
      s1_q          <= w_accept;
      s2_q          <= s1_q;
      ready_q       <= ready_d;
    end
  end

  // Coefficient banks: host writes land in shadow, SWAP copies shadow to active.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (i_cfg_we && w_addr_ok) begin
        shadow_q[slice_lsb(32'(iv_cfg_addr), DATA_WIDTH) +: DATA_WIDTH] <= iv_cfg_data;
      end
      if (state_q == ST_SWAP) begin
        active_q <= shadow_q;
      end
    end
  end

  fir_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_out_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (s2_q),
    .iv_push_data (iv_chain_sum),
    .i_pop        (w_pop),
    .ov_head      (ov_dout),
    .o_empty      (w_fifo_empty),
    .ov_count     (w_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_tap_ctrl
// Description : Testbench for fir_tap_ctrl with a behavioural transposed-form
//               tap chain and a scoreboard of expected filter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tap_ctrl;

  localparam int N  = 4;
  localparam int DW = 24;
  localparam int AW = 3;
  localparam int OD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   din = '0;
  logic            din_valid = 1'b0;
  logic            din_ready;
  logic            tap_en;
  logic [DW-1:0]   tap_din;
  logic [N*DW-1:0] weights;
  logic [DW-1:0]   chain_sum;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            dout_ready = 1'b1;
  logic            cfg_we = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [DW-1:0]   cfg_data = '0;
  logic            cfg_commit = 1'b0;
  logic            flush = 1'b0;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_tap_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_TAPS   (N),
    .ADDR_WIDTH (AW),
    .OUT_DEPTH  (OD)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .iv_din       (din),
    .i_din_valid  (din_valid),
    .o_din_ready  (din_ready),
    .o_tap_en     (tap_en),
    .ov_tap_din   (tap_din),
    .ov_weights   (weights),
    .iv_chain_sum (chain_sum),
    .ov_dout      (dout),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .i_cfg_we     (cfg_we),
    .iv_cfg_addr  (cfg_addr),
    .iv_cfg_data  (cfg_data),
    .i_cfg_commit (cfg_commit),
    .i_flush      (flush),
    .o_busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Q1.23 multiply with truncation, as each tap cell does.
  function automatic logic [DW-1:0] qmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = $signed(a) * $signed(b);
    return p[2*DW-2:DW-1];
  endfunction

  // External tap chain (transposed form); tap 0 is the chain output.
  logic [DW-1:0] chain_s [N];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) chain_s[k] <= '0;
    end else if (tap_en) begin
      for (int k = 0; k < N-1; k++)
        chain_s[k] <= qmul(tap_din, weights[k*DW +: DW]) + chain_s[k+1];
      chain_s[N-1] <= qmul(tap_din, weights[(N-1)*DW +: DW]);
    end
  end
  assign chain_sum = chain_s[0];

  // Reference model: sample history with the weight set active when each
  // sample entered the chain.
  logic [DW-1:0]   hx [N];
  logic [N*DW-1:0] hw [N];
  logic [N*DW-1:0] exp_w  = '0;
  logic [N*DW-1:0] exp_sh = '0;

  function automatic logic [DW-1:0] model_step(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    for (int k = N-1; k > 0; k--) begin
      hx[k] = hx[k-1];
      hw[k] = hw[k-1];
    end
    hx[0] = x;
    hw[0] = exp_w;
    y = '0;
    for (int k = 0; k < N; k++) y = y + qmul(hx[k], hw[k][k*DW +: DW]);
    return y;
  endfunction

  logic [DW-1:0] exp_q [$];
  int unsigned   acc_q [$];
  int unsigned   cyc = 0;
  bit            lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push at acceptance, pop and compare at consumption.
  always @(negedge clk) begin
    if (!rst) begin
      if (din_valid && din_ready) begin
        exp_q.push_back(model_step(din));
        acc_q.push_back(cyc);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_has_entry", exp_q.size(), 1);
        end else begin
          logic [DW-1:0] e;
          int unsigned   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check_eq("dout", dout, e);
          if (lat_chk) check_eq("dout_latency", cyc - a - 1, 2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      hx[k] = '0;
      hw[k] = '0;
    end
    exp_w  = '0;
    exp_sh = '0;
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic model_flush();
    repeat (N) void'(model_step('0));
  endtask

  task automatic send(input logic [DW-1:0] x);
    bit done;
    done = 1'b0;
    din = x;
    din_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (din_ready) done = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    if (!done) check_eq("send_accepted", done, 1);
  endtask

  task automatic cfg_write(input int a, input logic [DW-1:0] d);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (a < N) exp_sh[a*DW +: DW] = d;
  endtask

  task automatic commit_req();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    exp_w = exp_sh;
  endtask

  task automatic flush_req();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && (busy || !din_ready); i++) tick();
    check_eq(tag, {busy, din_ready}, 2'b01);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    tick();
    check_eq("drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, bad, pulses, nz, vcyc;
    int unsigned c0;
    bit first_seen;
    logic [N*DW-1:0] w_at_flush;
    logic [DW-1:0] last_din;

    model_clear();
    // Reset state
    tick();
    tick();
    check_eq("rst_tap_en", tap_en, 0);
    check_eq("rst_tap_din", tap_din, 0);
    check_eq("rst_dout_valid", dout_valid, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_weights", weights, 0);
    check_eq("rst_din_ready", din_ready, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    wait_idle("post_reset");

    // Out-of-range coefficient address is ignored
    cfg_write(5, 24'h7FFFFF);
    commit_req();
    wait_idle("addr_commit");
    check_eq("addr_ignored_weights", weights, exp_w);

    // Impulse: all weights 0.5, input 0.5 then zeros
    for (int k = 0; k < N; k++) cfg_write(k, 24'h400000);
    commit_req();
    wait_idle("impulse_commit");
    check_eq("impulse_weights", weights, exp_w);
    lat_chk = 1'b1;
    c0 = cyc;
    send(24'h400000);
    for (int i = 0; i < 7; i++) send(24'h000000);
    check_eq("impulse_throughput", cyc - c0, 8);
    wait_drain();
    lat_chk = 1'b0;

    // Backpressure: consumer stalled, continuous stream
    dout_ready = 1'b0;
    acc = 0;
    last_din = '0;
    for (int i = 0; i < 12; i++) begin
      din = DW'(24'h100000 + acc * 24'h040000);
      din_valid = 1'b1;
      if (din_ready) begin
        acc++;
        last_din = din;
      end
      tick();
    end
    din_valid = 1'b0;
    check_eq("bp_accepts", acc, OD);
    check_eq("bp_ready_low", din_ready, 0);
    check_eq("bp_dout_valid", dout_valid, 1);
    check_eq("bp_tap_din_hold", tap_din, last_din);
    dout_ready = 1'b1;
    wait_drain();
    wait_idle("bp_idle");

    // Bank swap mid-stream
    cfg_write(0, 24'h400000);
    for (int k = 1; k < N; k++) cfg_write(k, 24'h000000);
    commit_req();
    wait_idle("swap_setup");
    send(24'h400000);
    send(24'h200000);
    cfg_write(0, 24'h200000);
    check_eq("swap_shadow_not_active", weights, exp_w);
    send(24'h400000);
    din = 24'h400000;
    din_valid = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    exp_w = exp_sh;
    bad = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (din_ready) bad++;
      tick();
    end
    check_eq("swap_ready_low", bad, 0);
    check_eq("swap_weights", weights, exp_w);
    send(24'h400000);
    send(24'h200000);
    wait_drain();

    // Flush
    for (int k = 0; k < N; k++) cfg_write(k, 24'h400000);
    commit_req();
    wait_idle("flush_setup");
    send(24'h400000);
    wait_drain();
    flush_req();
    pulses = 0;
    nz = 0;
    vcyc = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (tap_en) begin
        pulses++;
        if (tap_din != '0) nz++;
      end
      if (dout_valid) vcyc++;
      tick();
    end
    check_eq("flush_pulses", pulses, N);
    check_eq("flush_nonzero_din", nz, 0);
    check_eq("flush_no_push", vcyc, 0);
    wait_idle("flush_done");
    send(24'h000000);
    wait_drain();

    // Simultaneous commit and flush
    for (int k = 0; k < N; k++) cfg_write(k, 24'h200000);
    cfg_commit = 1'b1;
    flush = 1'b1;
    tick();
    cfg_commit = 1'b0;
    flush = 1'b0;
    exp_w = exp_sh;
    model_flush();
    pulses = 0;
    bad = 0;
    first_seen = 1'b0;
    w_at_flush = '0;
    for (int i = 0; i < 100 && busy; i++) begin
      if (tap_en) begin
        pulses++;
        if (!first_seen) begin
          first_seen = 1'b1;
          w_at_flush = weights;
        end
      end
      if (din_ready) bad++;
      tick();
    end
    check_eq("sim_pulses", pulses, N);
    check_eq("sim_swap_before_flush", w_at_flush, exp_w);
    check_eq("sim_ready_low", bad, 0);
    check_eq("sim_busy_end", busy, 0);
    send(24'h400000);
    wait_drain();

    // Reset during the second flush step
    send(24'h400000);
    wait_drain();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100 && pulses < 2; i++) begin
      if (tap_en) pulses++;
      if (pulses < 2) tick();
    end
    check_eq("rstf_second_step", pulses, 2);
    rst = 1'b1;
    tick();
    check_eq("rstf_tap_en", tap_en, 0);
    check_eq("rstf_dout_valid", dout_valid, 0);
    check_eq("rstf_weights", weights, 0);
    check_eq("rstf_busy", busy, 0);
    check_eq("rstf_din_ready", din_ready, 0);
    rst = 1'b0;
    model_clear();
    wait_idle("rstf_idle");
    commit_req();
    wait_idle("rstf_commit");
    check_eq("rstf_shadow_cleared", weights, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
